sram_lat_model: RTL and testbench

- Parametrised successor to the fixed 1-cycle SRAM model that sits behind a TL-UL SRAM adapter in the pure_ibex_uart playground.
- Native req/gnt SRAM-side interface with configurable data width, memory depth and read latency.
- Up to RspDepth outstanding reads, response back-pressure (rready_i), wait-state injection (stall_i), and out-of-range error signalling on rerror_o.

---
 rtl/sram_lat_model.sv | 219 +++++++++++++++++++++
 tb/tb_sram_lat_model.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_lat_model.sv
// rtl/sram_lat_model.sv - SRAM model with req/gnt interface, configurable read latency and response queue
//
// Single-port word-addressed memory behind a native req/gnt interface.
// Reads travel through a ReadLatency-deep pipeline into a RspDepth-entry
// response FIFO. The number of in-flight reads (pipeline + FIFO) is bounded
// by RspDepth, so the FIFO can never overflow.
//
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset (memory contents are kept)
//   req_i     request valid
//   gnt_o     request accepted this cycle
//   we_i      1 = write, 0 = read
//   addr_i    word address
//   wdata_i   write data
//   wmask_i   per-byte write enables
//   stall_i   wait-state injection, blocks all grants
//   rvalid_o  read response valid
//   rready_i  response consumer ready
//   rdata_o   read data (0 while rvalid_o = 0)
//   rerror_o  {uncorrectable, correctable}; bit0 flags an out-of-range read

module sram_lat_model #(
  parameter int    AddrW       = 14,
  parameter int    DataW       = 32,
  parameter int    MemDepth    = 16384,
  parameter int    ReadLatency = 1,
  parameter int    RspDepth    = 2,
  parameter string InitHex     = ""
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic               we_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [DataW-1:0]   wdata_i,
  input  logic [DataW/8-1:0] wmask_i,
  input  logic               stall_i,
  output logic               rvalid_o,
  input  logic               rready_i,
  output logic [DataW-1:0]   rdata_o,
  output logic [1:0]         rerror_o
);

  localparam int MaskW = DataW / 8;
  localparam int IdxW  = (MemDepth > 1) ? $clog2(MemDepth) : 1;
  localparam int CntW  = $clog2(RspDepth + 1);
  localparam int PtrW  = (RspDepth > 1) ? $clog2(RspDepth) : 1;

  localparam logic [AddrW:0]  DepthLim = (AddrW + 1)'(MemDepth);
  localparam logic [CntW-1:0] CntMax   = CntW'(RspDepth);
  localparam logic [PtrW-1:0] PtrLast  = PtrW'(RspDepth - 1);

  // Elaboration-time parameter legality
  if (DataW < 8 || (DataW % 8) != 0) begin : g_bad_dataw
    $error("sram_lat_model: DataW must be a positive multiple of 8");
  end
  if (AddrW < 1 || MemDepth < 1 || MemDepth > (2 ** AddrW)) begin : g_bad_depth
    $error("sram_lat_model: MemDepth must be in 1..2**AddrW");
  end
  if (ReadLatency < 1 || ReadLatency > 8) begin : g_bad_lat
    $error("sram_lat_model: ReadLatency must be in 1..8");
  end
  if (RspDepth < 1 || RspDepth > 8) begin : g_bad_rsp
    $error("sram_lat_model: RspDepth must be in 1..8");
  end

  // --------------------------------------------------------------------------
  // Memory array
  // --------------------------------------------------------------------------
  logic [DataW-1:0] mem [MemDepth];

  logic [IdxW-1:0] idx;
  logic            in_range;
  logic [CntW-1:0] outstanding;
  logic            credit;
  logic            acc_rd;
  logic            acc_wr;
  logic [DataW-1:0] rd_word;
  logic [1:0]       rd_err;

  // Upper address bits are only used for the range check; idx alone could
  // alias an out-of-range address onto a real word.
  assign idx      = addr_i[IdxW-1:0];
  assign in_range = {1'b0, addr_i} < DepthLim;

  // Grant uses the registered count, so a pop this cycle frees credit only
  // from the next cycle on. Writes never consume read credit.
  assign credit = outstanding < CntMax;
  assign gnt_o  = req_i & ~stall_i & ~rst_i & (we_i | credit);
  assign acc_rd = gnt_o & ~we_i;
  assign acc_wr = gnt_o & we_i;

  // Pre-edge contents: the read is captured before any later write lands.
  assign rd_word = in_range ? mem[idx] : '0;
  assign rd_err  = in_range ? 2'b00 : 2'b01;

  always_ff @(posedge clk_i) begin
    if (acc_wr && in_range) begin
      for (int b = 0; b < MaskW; b++) begin
        if (wmask_i[b]) mem[idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Latency pipeline: the accept edge is the first of ReadLatency edges, so
  // only ReadLatency-1 register stages sit between accept and FIFO push.
  // --------------------------------------------------------------------------
  logic             push_v;
  logic [DataW-1:0] push_d;
  logic [1:0]       push_e;

  if (ReadLatency == 1) begin : g_nopipe
    assign push_v = acc_rd;
    assign push_d = rd_word;
    assign push_e = rd_err;
  end else begin : g_pipe
    localparam int Stages = ReadLatency - 1;

    logic [Stages-1:0] stg_v;
    logic [DataW-1:0]  stg_d [Stages];
    logic [1:0]        stg_e [Stages];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        stg_v <= '0;
        for (int i = 0; i < Stages; i++) begin
          stg_d[i] <= '0;
          stg_e[i] <= '0;
        end
      end else begin
        stg_v[0] <= acc_rd;
        stg_d[0] <= rd_word;
        stg_e[0] <= rd_err;
        for (int i = 1; i < Stages; i++) begin
          stg_v[i] <= stg_v[i-1];
          stg_d[i] <= stg_d[i-1];
          stg_e[i] <= stg_e[i-1];
        end
      end
    end

    assign push_v = stg_v[Stages-1];
    assign push_d = stg_d[Stages-1];
    assign push_e = stg_e[Stages-1];
  end

  // --------------------------------------------------------------------------
  // Response FIFO (circular buffer; depth need not be a power of two)
  // --------------------------------------------------------------------------
  logic [DataW-1:0] fifo_d [RspDepth];
  logic [1:0]       fifo_e [RspDepth];
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [CntW-1:0]  fifo_cnt;
  logic             pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign rvalid_o = fifo_cnt != '0;
  assign pop      = rvalid_o & rready_i;
  assign rdata_o  = rvalid_o ? fifo_d[rd_ptr] : '0;
  assign rerror_o = rvalid_o ? fifo_e[rd_ptr] : 2'b00;

  always_ff @(posedge clk_i) begin
    if (push_v) begin
      fifo_d[wr_ptr] <= push_d;
      fifo_e[wr_ptr] <= push_e;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_v) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({push_v, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CntW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CntW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outstanding reads: everything accepted and not yet popped
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding <= '0;
    end else begin
      case ({acc_rd, pop})
        2'b10:   outstanding <= outstanding + CntW'(1);
        2'b01:   outstanding <= outstanding - CntW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
  a_gnt_needs_req: assert property (@(posedge clk_i) disable iff (rst_i) gnt_o |-> req_i)
    else $error("sram_lat_model: gnt_o without req_i");
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) push_v |-> (fifo_cnt != CntMax))
    else $error("sram_lat_model: push into full response FIFO");
  a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> (fifo_cnt != '0))
    else $error("sram_lat_model: pop from empty response FIFO");
  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i) outstanding <= CntMax)
    else $error("sram_lat_model: outstanding count above RspDepth");

endmodule

// File: tb/tb_sram_lat_model.sv
// tb/tb_sram_lat_model.sv - scoreboard testbench for sram_lat_model
module tb_sram_lat_model;

  localparam int AW  = 11;
  localparam int DW  = 32;
  localparam int MD  = 1000;
  localparam int LAT = 3;
  localparam int RD  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          gnt;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wmask = '0;
  logic          stall = 1'b0;
  logic          rvalid;
  logic          rready = 1'b0;
  logic [DW-1:0] rdata;
  logic [1:0]    rerror;

  always #5 clk = ~clk;

  sram_lat_model #(
    .AddrW(AW), .DataW(DW), .MemDepth(MD), .ReadLatency(LAT), .RspDepth(RD), .InitHex("")
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .wmask_i(wmask), .stall_i(stall), .rvalid_o(rvalid),
    .rready_i(rready), .rdata_o(rdata), .rerror_o(rerror)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    longint      acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [MD];
  longint      cyc = 0;
  longint      last_pop = -1;
  longint      vis_c;
  int          n_chk = 0;
  int          n_pass = 0;
  int          stall_pct = 0;
  int          rready_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference behaviour for an accepted request
  task automatic model_accept(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                              input logic [3:0] m);
    exp_t e;
    if (w) begin
      if (a < MD) begin
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
      end
    end else begin
      e.acc = cyc;
      if (a < MD) begin
        e.data = ref_mem[a];
        e.err  = 2'b00;
      end else begin
        e.data = 32'h0;
        e.err  = 2'b01;
      end
      exp_q.push_back(e);
    end
  endtask

  // One bus cycle: drive after the edge, check grant, record acceptance
  task automatic drive(input bit r, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit st, input bit rr, output bit accepted);
    bit exp_gnt;
    @(posedge clk);
    #1;
    req = r; we = w; addr = a; wdata = d; wmask = m; stall = st; rready = rr;
    #1;
    exp_gnt = r && !st && !rst && (w || (exp_q.size() < RD));
    chk("gnt", gnt, exp_gnt);
    accepted = r && gnt;
    if (accepted) model_accept(w, a, d, m);
  endtask

  task automatic issue(input bit w, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    bit ok = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      drive(1'b1, w, a, d, m, $urandom_range(0, 99) < stall_pct,
            $urandom_range(0, 99) < rready_pct, ok);
    end
    chk("grant_bound", ok, 1);
  endtask

  task automatic drain();
    bit dummy;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, dummy);
    end
    chk("drain_bound", exp_q.size() == 0, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; req = 1'b1; we = 1'b0; stall = 1'b0; rready = 1'b1;
    exp_q.delete();
    #1;
    chk("gnt_in_reset", gnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;
  endtask

  // Monitor: cycle-exact response timing and content against the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      chk("rvalid_in_reset", rvalid, 0);
    end else begin
      if (exp_q.size() != 0) begin
        vis_c = exp_q[0].acc + LAT;
        if (last_pop + 1 > vis_c) vis_c = last_pop + 1;
      end
      if (exp_q.size() == 0 || cyc < vis_c) begin
        chk("idle_outputs", {rvalid, rerror, rdata}, 35'h0);
      end else begin
        chk("rvalid_due", rvalid, 1);
        if (rvalid) begin
          chk("rsp_data", rdata, exp_q[0].data);
          chk("rsp_err", rerror, exp_q[0].err);
          if (rready) begin
            void'(exp_q.pop_front());
            last_pop = cyc;
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    req = 1'b1;
    #7;
    chk("reset_gnt", gnt, 0);
    chk("reset_outputs", {rvalid, rerror, rdata}, 35'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; req = 1'b0;

    // Fill memory so every in-range word has a known value
    for (int a = 0; a < MD; a++) issue(1'b1, AW'(a), $urandom, 4'hF);

    // Basic write/read
    issue(1'b1, 'h10, 32'hDEADBEEF, 4'hF);
    issue(1'b0, 'h10, '0, '0);
    drain();

    // Byte mask
    issue(1'b1, 'h11, 32'h11223344, 4'hF);
    issue(1'b1, 'h11, 32'hAABBCCDD, 4'b0101);
    issue(1'b0, 'h11, '0, '0);
    drain();

    // Full credit with back-pressure: third read blocked, write still granted
    drive(1'b1, 1'b0, 'h40, '0, '0, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 'h41, '0, '0, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 'h42, '0, '0, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b1, 'h43, 32'h1234, 4'hF, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 'h42, '0, '0, 1'b0, 1'b0, acc);
    rready_pct = 100;
    issue(1'b0, 'h42, '0, '0);
    issue(1'b0, 'h43, '0, '0);
    drain();

    // Out-of-range reads and writes (including an address aliasing word 0x10)
    issue(1'b0, AW'(MD), '0, '0);
    issue(1'b0, AW'(2047), '0, '0);
    issue(1'b1, AW'(MD), 32'hFFFFFFFF, 4'hF);
    issue(1'b1, AW'(1024 + 'h10), 32'hCAFEF00D, 4'hF);
    issue(1'b0, 'h10, '0, '0);
    issue(1'b0, AW'(MD - 1), '0, '0);
    drain();

    // Stall, then read-before-write hazard on the same word
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 'h20, '0, '0, 1'b1, 1'b1, acc);
    issue(1'b1, 'h20, 32'h5, 4'hF);
    issue(1'b0, 'h20, '0, '0);
    issue(1'b1, 'h20, 32'h9, 4'hF);
    issue(1'b0, 'h20, '0, '0);
    drain();

    // Reset while two reads are in flight
    issue(1'b0, 'h30, '0, '0);
    issue(1'b0, 'h31, '0, '0);
    pulse_reset();
    issue(1'b0, 'h32, '0, '0);
    drain();

    // Randomized traffic with stalls and back-pressure
    stall_pct = 20;
    rready_pct = 70;
    for (int i = 0; i < 500; i++) begin
      issue($urandom_range(0, 1), AW'($urandom_range(0, 1199)), $urandom,
            4'($urandom_range(0, 15)));
    end
    stall_pct = 0;
    rready_pct = 100;
    drain();

    // Full readback: out-of-range writes must not have touched any word
    for (int a = 0; a < MD; a++) issue(1'b0, AW'(a), '0, '0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
